// File: rtl/dnn_pkg.sv
// Shared constants and FSM encoding for the dnn_top operand feeder.
package dnn_pkg;

    localparam int I_W         = 5;
    localparam int BATCH_WORDS = 28;
    localparam int ADDR_W      = $clog2(BATCH_WORDS);

    // Word positions inside one buffered batch
    localparam int X_BASE  = 0;
    localparam int W1_BASE = 4;
    localparam int W2_BASE = 20;
    localparam int NUM_X   = 4;
    localparam int NUM_W1  = 16;
    localparam int NUM_W2  = 8;

    typedef enum logic [2:0] {
        IDLE,
        PH_X,
        PH_W1,
        WAIT1,
        WAIT2,
        PH_W2
    } state_t;

endpackage

// File: rtl/dnn_bank.sv
// One batch buffer: 28 words written serially, read in parallel, with a full flag.
module dnn_bank
    import dnn_pkg::*;
#(
    parameter int W = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [W-1:0]                       wdata,
    input  logic                               mark,
    input  logic                               clr,
    output logic                               full,
    output logic [BATCH_WORDS-1:0][W-1:0]      rdata
);

    logic mark_q;

    // Storage: contents are only meaningful while full, so no reset is needed
    always_ff @(posedge clk) begin
        if (we) rdata[waddr] <= wdata;
    end

    // Full rises one cycle after the closing word lands; the issue side frees it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mark_q <= 1'b0;
            full   <= 1'b0;
        end else begin
            mark_q <= mark;
            if (clr)         full <= 1'b0;
            else if (mark_q) full <= 1'b1;
        end
    end

endmodule

// File: rtl/dnn_feeder.sv
// Ping-pong batch buffer and phase sequencer driving the dnn_top operand ports.
module dnn_feeder
    import dnn_pkg::*;
#(
    parameter int I_W = dnn_pkg::I_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [I_W-1:0] s_data,
    input  logic           s_last,
    output logic [I_W-1:0] x0, x1, x2, x3,
    output logic [I_W-1:0] w04, w05, w06, w07,
    output logic [I_W-1:0] w14, w15, w16, w17,
    output logic [I_W-1:0] w24, w25, w26, w27,
    output logic [I_W-1:0] w34, w35, w36, w37,
    output logic [I_W-1:0] w48, w49, w58, w59,
    output logic [I_W-1:0] w68, w69, w78, w79,
    output logic           in_ready,
    output logic [7:0]     batch_cnt,
    output logic           err
);

    logic                                      wr_sel, rd_sel;
    logic [ADDR_W-1:0]                         wr_cnt;
    logic                                      acc, last_word;
    logic [1:0]                                bank_full, bank_we, bank_mark, bank_clr;
    logic [1:0][BATCH_WORDS-1:0][I_W-1:0]      bank_data;
    logic [BATCH_WORDS-1:0][I_W-1:0]           rd_word;
    logic [NUM_X-1:0][I_W-1:0]                 x_q;
    logic [NUM_W1-1:0][I_W-1:0]                w1_q;
    logic [NUM_W2-1:0][I_W-1:0]                w2_q;
    state_t                                    state, nxt;
    logic                                      ld_x, ld_w1, ld_w2;

    assign s_ready   = ~bank_full[wr_sel];
    assign acc       = s_valid & s_ready;
    assign last_word = (wr_cnt == ADDR_W'(BATCH_WORDS - 1));
    assign rd_word   = bank_data[rd_sel];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]   = acc & (wr_sel == 1'(b));
        assign bank_mark[b] = bank_we[b] & last_word;
        // ld_w2 is the last use of the bank, so it is released on that edge
        assign bank_clr[b]  = ld_w2 & (rd_sel == 1'(b));

        dnn_bank #(.W(I_W)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bank_we[b]),
            .waddr (wr_cnt),
            .wdata (s_data),
            .mark  (bank_mark[b]),
            .clr   (bank_clr[b]),
            .full  (bank_full[b]),
            .rdata (bank_data[b])
        );
    end

    // Fill side: count words, swap banks on the 28th, flag framing mismatches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
            err    <= 1'b0;
        end else if (acc) begin
            if (s_last != last_word) err <= 1'b1;
            if (last_word) begin
                wr_cnt <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Issue FSM next state and load strobes
    always_comb begin
        nxt   = state;
        ld_x  = 1'b0;
        ld_w1 = 1'b0;
        ld_w2 = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rd_sel]) begin
                    nxt  = PH_X;
                    ld_x = 1'b1;
                end
            end
            PH_X: begin
                nxt   = PH_W1;
                ld_w1 = 1'b1;
            end
            PH_W1: nxt = WAIT1;
            WAIT1: nxt = WAIT2;
            WAIT2: begin
                nxt   = PH_W2;
                ld_w2 = 1'b1;
            end
            PH_W2: begin
                // rd_sel already points at the other bank here
                if (bank_full[rd_sel]) begin
                    nxt  = PH_X;
                    ld_x = 1'b1;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Output registers: load per phase, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q       <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            in_ready  <= 1'b0;
            rd_sel    <= 1'b0;
            batch_cnt <= '0;
        end else begin
            if (ld_x) begin
                x_q      <= rd_word[X_BASE +: NUM_X];
                in_ready <= 1'b1;
            end
            if (ld_w1) w1_q <= rd_word[W1_BASE +: NUM_W1];
            if (ld_w2) begin
                w2_q      <= rd_word[W2_BASE +: NUM_W2];
                in_ready  <= 1'b0;
                rd_sel    <= ~rd_sel;
                batch_cnt <= batch_cnt + 8'd1;
            end
        end
    end

    assign {x3, x2, x1, x0} = x_q;
    assign {w37, w36, w35, w34, w27, w26, w25, w24,
            w17, w16, w15, w14, w07, w06, w05, w04} = w1_q;
    assign {w79, w78, w69, w68, w59, w58, w49, w48} = w2_q;

endmodule

// File: tb/tb_dnn_feeder.sv
// Randomized bench for dnn_feeder against a batch-level scoreboard.
module tb_dnn_feeder;

    typedef logic [139:0] val_t;
    typedef struct packed { logic last; logic [4:0] d; } word_t;
    typedef struct { logic [27:0][4:0] w; int e; } batch_t;

    logic clk, rst_n, s_valid, s_ready, s_last, in_ready, err;
    logic [4:0] s_data;
    logic [4:0] x0, x1, x2, x3;
    logic [4:0] w04, w05, w06, w07, w14, w15, w16, w17;
    logic [4:0] w24, w25, w26, w27, w34, w35, w36, w37;
    logic [4:0] w48, w49, w58, w59, w68, w69, w78, w79;
    logic [7:0] batch_cnt;
    logic [27:0][4:0] dv;

    dnn_feeder #(.I_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .w04(w04), .w05(w05), .w06(w06), .w07(w07),
        .w14(w14), .w15(w15), .w16(w16), .w17(w17),
        .w24(w24), .w25(w25), .w26(w26), .w27(w27),
        .w34(w34), .w35(w35), .w36(w36), .w37(w37),
        .w48(w48), .w49(w49), .w58(w58), .w59(w59),
        .w68(w68), .w69(w69), .w78(w78), .w79(w79),
        .in_ready(in_ready), .batch_cnt(batch_cnt), .err(err)
    );

    // Outputs gathered in stream word order
    assign dv = {w79, w78, w69, w68, w59, w58, w49, w48,
                 w37, w36, w35, w34, w27, w26, w25, w24,
                 w17, w16, w15, w14, w07, w06, w05, w04,
                 x3, x2, x1, x0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;

    // Model state
    word_t  stim[$];
    batch_t bq[$];
    batch_t cur;
    logic [27:0][4:0] part;
    word_t  pend_word;
    logic   pend_acc = 1'b0;
    int     wi = 0, nbuf = 0, ph = 0, fall_cyc = -100, exp_rise = 0;
    logic   active = 1'b0, prev_ir = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_cnt = 8'd0;
    int     gap_mode = 0;
    logic   rst_pend = 1'b0, rst_at_wait1 = 1'b0;

    task automatic chk(input string tag, input val_t got, input val_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        stim.delete();
        bq.delete();
        wi = 0; nbuf = 0; ph = 0; fall_cyc = -100;
        active = 1'b0; prev_ir = 1'b0; exp_err = 1'b0; exp_cnt = 8'd0;
    endtask

    task automatic add_batch(input logic [27:0][4:0] w, input int bad_idx);
        for (int i = 0; i < 28; i++) begin
            word_t t;
            t.d    = w[i];
            t.last = (i == 27) || (i == bad_idx);
            stim.push_back(t);
        end
    endtask

    // One clock: observe the edge just taken, then drive the next cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_pend) begin
            chk("rst_outputs", val_t'(dv), val_t'(0));
            chk("rst_in_ready", val_t'(in_ready), val_t'(0));
            chk("rst_batch_cnt", val_t'(batch_cnt), val_t'(0));
            chk("rst_err", val_t'(err), val_t'(0));
            chk("rst_s_ready", val_t'(s_ready), val_t'(1));
            model_clear();
            rst_pend = 1'b0;
            rst_n    = 1'b1;
        end else if (rst_n) begin
            if (pend_acc) begin
                part[wi] = pend_word.d;
                if (pend_word.last != (wi == 27)) exp_err = 1'b1;
                if (wi == 27) begin
                    batch_t nb;
                    nb.w = part;
                    nb.e = cyc;
                    bq.push_back(nb);
                    nbuf++;
                    wi = 0;
                end else begin
                    wi++;
                end
                void'(stim.pop_front());
            end
            chk("err", val_t'(err), val_t'(exp_err));
            if (active) begin
                ph++;
                if (ph == 1) chk("w1", val_t'(dv[19:4]), val_t'(cur.w[19:4]));
                if (ph < 4) begin
                    chk("in_ready_hi", val_t'(in_ready), val_t'(1));
                end else begin
                    chk("in_ready_lo", val_t'(in_ready), val_t'(0));
                    chk("batch_words", val_t'(dv), val_t'(cur.w));
                    exp_cnt = exp_cnt + 8'd1;
                    chk("batch_cnt", val_t'(batch_cnt), val_t'(exp_cnt));
                    nbuf--;
                    fall_cyc = cyc;
                    active = 1'b0;
                end
            end else if (in_ready && !prev_ir) begin
                if (bq.size() == 0) begin
                    chk("issue_without_batch", val_t'(in_ready), val_t'(0));
                end else begin
                    cur = bq.pop_front();
                    exp_rise = (cur.e + 2 > fall_cyc + 1) ? cur.e + 2 : fall_cyc + 1;
                    chk("issue_cycle", val_t'(cyc), val_t'(exp_rise));
                    chk("x", val_t'(dv[3:0]), val_t'(cur.w[3:0]));
                    active = 1'b1;
                    ph = 0;
                end
            end
            prev_ir = in_ready;
            chk("s_ready", val_t'(s_ready), val_t'(nbuf < 2));
        end
        pend_acc = 1'b0;
        if (rst_at_wait1 && active && ph == 2) begin
            rst_at_wait1 = 1'b0;
            rst_n    = 1'b0;
            rst_pend = 1'b1;
            s_valid  = 1'b0;
        end else if (rst_n && stim.size() > 0 &&
                     (gap_mode == 0 || (gap_mode == 1 && cyc % 2 == 0) ||
                      (gap_mode == 2 && $urandom_range(1, 0) == 1))) begin
            s_valid   = 1'b1;
            s_data    = stim[0].d;
            s_last    = stim[0].last;
            pend_word = stim[0];
            pend_acc  = s_ready;
        end else begin
            s_valid = 1'b0;
            s_data  = 5'($urandom);
            s_last  = 1'($urandom);
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((stim.size() > 0 || wi != 0 || bq.size() > 0 || active || pend_acc)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget)
            chk("drain_timeout", val_t'(stim.size() + bq.size() + wi + int'(active)), val_t'(0));
    endtask

    function automatic logic [27:0][4:0] rand_batch();
        logic [27:0][4:0] w;
        for (int i = 0; i < 28; i++) w[i] = 5'($urandom);
        return w;
    endfunction

    initial begin
        logic [27:0][4:0] w;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        rst_n = 1'b0; rst_pend = 1'b1;
        tick();

        // Ascending words 0..27
        for (int i = 0; i < 28; i++) w[i] = 5'(i);
        add_batch(w, -1);
        run(200);

        // Same data with a valid gap every other cycle
        gap_mode = 1;
        add_batch(w, -1);
        run(200);
        gap_mode = 0;

        // Three continuous batches with x = batch number
        for (int b = 1; b <= 3; b++) begin
            w = rand_batch();
            for (int i = 0; i < 4; i++) w[i] = 5'(b);
            add_batch(w, -1);
        end
        run(400);

        // Most negative operand everywhere
        for (int i = 0; i < 28; i++) w[i] = 5'h10;
        add_batch(w, -1);
        run(200);

        // Random data with random valid gaps
        gap_mode = 2;
        add_batch(rand_batch(), -1);
        add_batch(rand_batch(), -1);
        run(600);
        gap_mode = 0;

        // Early s_last on word 10: sticky err, batch still completes on count
        add_batch(rand_batch(), 9);
        add_batch(rand_batch(), -1);
        run(400);

        // Reset during WAIT1 while the next batch is partway in
        rst_at_wait1 = 1'b1;
        add_batch(rand_batch(), -1);
        add_batch(rand_batch(), -1);
        run(400);
        repeat (40) tick();
        chk("post_rst_batch_cnt", val_t'(batch_cnt), val_t'(exp_cnt));

        // Fresh batch after reset must be framed from word 0
        add_batch(rand_batch(), -1);
        run(200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
